instruction_fetch_unit: RTL and testbench

INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

---
 rtl/cpu_pkg.sv | 17 +
 rtl/fetch_hold_buffer.sv | 26 ++
 rtl/instruction_fetch_unit.sv | 117 +++++++++++
 tb/tb_instruction_fetch_unit.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared fetch state encoding and fetch constants
package cpu_pkg;

  typedef enum logic [1:0] {
    FETCH_REQ  = 2'd0,
    FETCH_WAIT = 2'd1,
    FETCH_HOLD = 2'd2
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] PC_INC    = 32'd4;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_hold_buffer.sv
// rtl/fetch_hold_buffer.sv - one-entry pc/instruction buffer for responses arriving under stall
module fetch_hold_buffer (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        clear,
  input  logic [31:0] pc_in,
  input  logic [31:0] instr_in,
  output logic [31:0] pc,
  output logic [31:0] instr
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc    <= '0;
      instr <= '0;
    end else if (clear) begin
      pc    <= '0;
      instr <= '0;
    end else if (load) begin
      pc    <= pc_in;
      instr <= instr_in;
    end
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - single-outstanding instruction fetch with stall hold and redirect kill
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = cpu_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic [31:0] pc_out,
  output logic [31:0] instruction_out,
  output logic        valid_out
);

  import cpu_pkg::*;

  fetch_state_t state, state_next;
  logic [31:0]  fetch_pc;
  logic         kill, kill_next;
  logic         running;
  logic         req_fire, accept, to_hold, from_hold;
  logic [31:0]  hold_pc, hold_instr;

  // running keeps the request line low until the first edge after reset release
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= FETCH_REQ;
      kill    <= 1'b0;
      running <= 1'b0;
    end else begin
      state   <= state_next;
      kill    <= kill_next;
      running <= 1'b1;
    end
  end

  // A response returning in the same cycle as a redirect is dropped on the spot,
  // so kill only stays armed while the killed request is still in flight.
  always_comb begin
    state_next = state;
    kill_next  = kill;
    case (state)
      FETCH_REQ: begin
        if (req_fire) begin
          state_next = FETCH_WAIT;
          kill_next  = redirect_valid;
        end
      end
      FETCH_WAIT: begin
        if (imem_rsp_valid) begin
          state_next = to_hold ? FETCH_HOLD : FETCH_REQ;
          kill_next  = 1'b0;
        end else if (redirect_valid) begin
          kill_next  = 1'b1;
        end
      end
      FETCH_HOLD: begin
        if (redirect_valid || !stall) state_next = FETCH_REQ;
      end
      default: state_next = FETCH_REQ;
    endcase
  end

  always_comb begin
    imem_req_valid = running && (state == FETCH_REQ);
    imem_addr      = word_align(fetch_pc);
    req_fire       = imem_req_valid && imem_req_ready;
    accept         = (state == FETCH_WAIT) && imem_rsp_valid && !kill && !redirect_valid;
    to_hold        = accept && stall && valid_out;
    from_hold      = (state == FETCH_HOLD) && !stall && !redirect_valid;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc        <= RESET_PC;
      pc_out          <= '0;
      instruction_out <= NOP_INSTR;
      valid_out       <= 1'b0;
    end else if (redirect_valid) begin
      fetch_pc        <= word_align(redirect_pc);
      instruction_out <= NOP_INSTR;
      valid_out       <= 1'b0;
    end else begin
      if (accept) fetch_pc <= fetch_pc + PC_INC;
      if (accept && !to_hold) begin
        pc_out          <= fetch_pc;
        instruction_out <= imem_rsp_data;
        valid_out       <= 1'b1;
      end else if (from_hold) begin
        pc_out          <= hold_pc;
        instruction_out <= hold_instr;
        valid_out       <= 1'b1;
      end else if (!stall) begin
        instruction_out <= NOP_INSTR;
        valid_out       <= 1'b0;
      end
    end
  end

  fetch_hold_buffer u_hold (
    .clk      (clk),
    .rst      (rst),
    .load     (to_hold),
    .clear    (redirect_valid),
    .pc_in    (fetch_pc),
    .instr_in (imem_rsp_data),
    .pc       (hold_pc),
    .instr    (hold_instr)
  );

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb/tb_instruction_fetch_unit.sv - directed and random checks of instruction_fetch_unit against a stream model
module tb_instruction_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0, redirect_valid = 1'b0, imem_req_ready = 1'b0, imem_rsp_valid = 1'b0;
  logic [31:0] redirect_pc = '0, imem_rsp_data = '0;
  logic        imem_req_valid, valid_out;
  logic [31:0] imem_addr, pc_out, instruction_out;

  logic        rsp2_valid = 1'b0;
  logic        req2_valid, valid2;
  logic [31:0] addr2, pc2, instr2;

  int          checks = 0, passed = 0, consumed = 0;
  bit          mem_pending = 0, r2_pending = 0;
  logic [31:0] mem_addr = '0, exp_pc = '0, held_pc;
  int          mem_lat = 0, n, n0;
  logic [31:0] req_log[$], req_log2[$];

  always #5 clk = ~clk;

  instruction_fetch_unit u_dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .pc_out(pc_out), .instruction_out(instruction_out), .valid_out(valid_out)
  );

  instruction_fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) u_dut_wrap (
    .clk(clk), .rst(rst), .stall(1'b0), .redirect_valid(1'b0), .redirect_pc(32'h0),
    .imem_req_valid(req2_valid), .imem_req_ready(1'b1), .imem_addr(addr2),
    .imem_rsp_valid(rsp2_valid), .imem_rsp_data(32'h0000_0013),
    .pc_out(pc2), .instruction_out(instr2), .valid_out(valid2)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'hC0DE_0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
  endtask

  // One clock: drive inputs, sample pre-edge, advance, then update memory and stream model.
  task automatic cycle(input bit stl, input bit rd, input logic [31:0] rpc, input bit rdy, input int lat);
    logic        pv, preq, preq2, rsp_now;
    logic [31:0] ppc, pin, paddr, paddr2;
    stall          = stl;
    redirect_valid = rd;
    redirect_pc    = rpc;
    imem_req_ready = rdy;
    rsp_now        = mem_pending && (mem_lat == 0);
    imem_rsp_valid = rsp_now;
    imem_rsp_data  = rsp_now ? mem_word(mem_addr) : $urandom;
    rsp2_valid     = r2_pending;
    #1;
    pv = valid_out; ppc = pc_out; pin = instruction_out;
    preq = imem_req_valid; paddr = imem_addr; preq2 = req2_valid; paddr2 = addr2;
    if (preq) begin
      chk("addr_align", {30'b0, paddr[1:0]}, 32'h0);
      chk1("one_outstanding", mem_pending, 1'b0);
    end
    @(posedge clk);
    #1;
    if (preq2) req_log2.push_back(paddr2);
    r2_pending = preq2;
    if (rsp_now) mem_pending = 0;
    else if (mem_pending) mem_lat--;
    if (preq && rdy) begin
      mem_pending = 1;
      mem_addr    = paddr;
      mem_lat     = (lat < 0) ? int'($urandom_range(3, 0)) : lat;
      req_log.push_back(paddr);
    end
    if (rd) begin
      chk1("redirect_valid_out", valid_out, 1'b0);
      exp_pc = {rpc[31:2], 2'b00};
    end else begin
      if (pv && !stl) begin
        chk("consume_pc", ppc, exp_pc);
        chk("consume_instr", pin, mem_word(exp_pc));
        exp_pc = exp_pc + 32'd4;
        consumed++;
      end
      if (pv && stl) begin
        chk("stall_pc", pc_out, ppc);
        chk("stall_instr", instruction_out, pin);
        chk1("stall_valid", valid_out, 1'b1);
      end
    end
    if (!valid_out) begin
      chk("bubble_pc", pc_out, ppc);
      chk("bubble_nop", instruction_out, NOP);
    end else begin
      chk("data_match", instruction_out, mem_word(pc_out));
    end
  endtask

  initial begin
    #2 rst = 1'b0;
    #1;
    chk("reset_pc_out", pc_out, 32'h0);
    chk("reset_instr", instruction_out, NOP);
    chk1("reset_valid", valid_out, 1'b0);
    chk1("reset_req_valid", imem_req_valid, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    // first edge after release issues RESET_PC; zero-latency streaming
    cycle(0, 0, 32'h0, 1, 0);
    chk1("first_req_valid", imem_req_valid, 1'b1);
    chk("first_req_addr", imem_addr, 32'h0);
    repeat (8) cycle(0, 0, 32'h0, 1, 0);
    chk("stream_req0", req_log[0], 32'h0);
    chk("stream_req1", req_log[1], 32'h4);
    chk("stream_req2", req_log[2], 32'h8);
    chk("wrap_req0", req_log2[0], 32'hFFFF_FFF8);
    chk("wrap_req1", req_log2[1], 32'hFFFF_FFFC);
    chk("wrap_req2", req_log2[2], 32'h0000_0000);

    // stall across a response: held in buffer, no new request, released in order
    n = 0;
    do begin cycle(0, 0, 32'h0, 1, 0); n++; end
    while (!(valid_out && imem_req_valid) && n < 20);
    chk1("hold_setup_reached", valid_out && imem_req_valid, 1'b1);
    held_pc = pc_out;
    cycle(1, 0, 32'h0, 1, 0);
    cycle(1, 0, 32'h0, 1, 0);
    chk1("hold_no_req_a", imem_req_valid, 1'b0);
    cycle(1, 0, 32'h0, 1, 0);
    chk1("hold_no_req_b", imem_req_valid, 1'b0);
    chk("hold_frozen_pc", pc_out, held_pc);
    cycle(0, 0, 32'h0, 1, 0);
    chk1("hold_release_valid", valid_out, 1'b1);
    chk("hold_release_pc", pc_out, held_pc + 32'd4);

    // redirect while waiting on a slow response
    n = 0;
    do begin cycle(0, 0, 32'h0, 1, 3); n++; end
    while (!mem_pending && n < 10);
    chk1("wait_reached", mem_pending, 1'b1);
    cycle(0, 1, 32'h0000_0100, 1, 3);
    n0 = req_log.size();
    repeat (12) cycle(0, 0, 32'h0, 1, 0);
    chk("redirect_addr", (req_log.size() > n0) ? req_log[n0] : 32'hDEAD_BEEF, 32'h0000_0100);

    // unaligned redirect target
    cycle(0, 1, 32'h0000_0203, 1, -1);
    n0 = req_log.size();
    repeat (10) cycle(0, 0, 32'h0, 1, 0);
    chk("redirect_align", (req_log.size() > n0) ? req_log[n0] : 32'hDEAD_BEEF, 32'h0000_0200);

    // asynchronous reset in the middle of a transaction
    n = 0;
    do begin cycle(0, 0, 32'h0, 1, 10); n++; end
    while (!mem_pending && n < 10);
    cycle(0, 0, 32'h0, 0, 10);
    #3 rst = 1'b0;
    #1;
    chk("midreset_pc_out", pc_out, 32'h0);
    chk("midreset_instr", instruction_out, NOP);
    chk1("midreset_valid", valid_out, 1'b0);
    chk1("midreset_req", imem_req_valid, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    mem_pending = 0;
    r2_pending  = 0;
    exp_pc      = 32'h0;
    req_log.delete();
    for (int i = 0; i < 5; i++) begin
      cycle(0, 0, 32'h0, 0, 0);
      chk1("restart_req_valid", imem_req_valid, 1'b1);
      chk("restart_addr", imem_addr, 32'h0);
    end

    // random traffic against the stream model
    consumed = 0;
    for (int i = 0; i < 600; i++) begin
      cycle(($urandom % 10) < 3, ($urandom % 25) == 0, $urandom, ($urandom % 10) < 7, -1);
    end
    chk1("random_progress", consumed >= 40, 1'b1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
